// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the rPLL supervisor / reconfiguration controller.
package pll_ctrl_pkg;

    typedef enum logic [1:0] {
        RST_HOLD  = 2'd0,
        WAIT_LOCK = 2'd1,
        LOCKED    = 2'd2,
        FAIL      = 2'd3
    } pll_state_e;

    // Width of a counter that must be able to hold the value n itself.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_if.sv
// Divider-setting handshake between a configuration master and the PLL controller.
interface pll_reconfig_ctrl_if #(
    parameter int IDIV_W  = 6,
    parameter int FBDIV_W = 6,
    parameter int ODIV_W  = 6
);

    logic               cfg_valid;
    logic               cfg_ready;
    logic [IDIV_W-1:0]  cfg_idsel;
    logic [FBDIV_W-1:0] cfg_fbdsel;
    logic [ODIV_W-1:0]  cfg_odsel;

    modport master (
        output cfg_valid,
        output cfg_idsel,
        output cfg_fbdsel,
        output cfg_odsel,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_idsel,
        input  cfg_fbdsel,
        input  cfg_odsel,
        output cfg_ready
    );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for signals arriving asynchronously to clk.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Supervisor for an rPLL in dynamic-divider mode: sequences RESET, qualifies lock,
// retries on timeout, relocks after lock loss and applies new divider settings.
module pll_reconfig_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int                 IDIV_W       = 6,
    parameter int                 FBDIV_W      = 6,
    parameter int                 ODIV_W       = 6,
    parameter logic [IDIV_W-1:0]  IDSEL_INIT   = '0,
    parameter logic [FBDIV_W-1:0] FBDSEL_INIT  = '0,
    parameter logic [ODIV_W-1:0]  ODSEL_INIT   = '0,
    parameter int                 RST_CYCLES   = 16,
    parameter int                 LOCK_FILTER  = 64,
    parameter int                 LOCK_TIMEOUT = 65536,
    parameter int                 MAX_RETRY    = 3
) (
    input  logic               clkin,
    input  logic               reset,
    pll_reconfig_ctrl_if.slave cfg,
    input  logic               pll_lock,
    output logic               pll_reset,
    output logic [IDIV_W-1:0]  pll_idsel,
    output logic [FBDIV_W-1:0] pll_fbdsel,
    output logic [ODIV_W-1:0]  pll_odsel,
    output logic               locked,
    output logic               busy,
    output logic               err,
    output logic [7:0]         lock_loss_cnt
);

    localparam int RST_W  = cnt_w(RST_CYCLES);
    localparam int FILT_W = cnt_w(LOCK_FILTER);
    localparam int TMO_W  = cnt_w(LOCK_TIMEOUT);
    localparam int RTY_W  = cnt_w(MAX_RETRY);

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_DONE = FILT_W'(LOCK_FILTER);
    localparam logic [TMO_W-1:0]  TMO_DONE  = TMO_W'(LOCK_TIMEOUT);
    localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);

    pll_state_e         state_q,    state_d;
    logic [RST_W-1:0]   rst_cnt_q,  rst_cnt_d;
    logic [FILT_W-1:0]  filt_cnt_q, filt_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q,  tmo_cnt_d;
    logic [RTY_W-1:0]   retry_q,    retry_d;
    logic [7:0]         loss_q,     loss_d;
    logic [IDIV_W-1:0]  idsel_q,    idsel_d;
    logic [FBDIV_W-1:0] fbdsel_q,   fbdsel_d;
    logic [ODIV_W-1:0]  odsel_q,    odsel_d;

    logic lock_s;
    logic cfg_ready_w;
    logic accept;

    sync_2ff #(.W(1)) u_lock_sync (
        .clk (clkin),
        .rst (reset),
        .d   (pll_lock),
        .q   (lock_s)
    );

    assign cfg_ready_w = (state_q == LOCKED) || (state_q == FAIL);
    assign accept      = cfg.cfg_valid && cfg_ready_w;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        rst_cnt_d  = '0;
        filt_cnt_d = '0;
        tmo_cnt_d  = '0;
        retry_d    = retry_q;
        loss_d     = loss_q;
        idsel_d    = idsel_q;
        fbdsel_d   = fbdsel_q;
        odsel_d    = odsel_q;

        case (state_q)
            RST_HOLD: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end

            WAIT_LOCK: begin
                tmo_cnt_d  = tmo_cnt_q + 1'b1;
                filt_cnt_d = lock_s ? filt_cnt_q + 1'b1 : '0;
                // Filter completion is tested first so a lock on the final cycle still counts.
                if (filt_cnt_d == FILT_DONE) begin
                    state_d    = LOCKED;
                    tmo_cnt_d  = '0;
                    filt_cnt_d = '0;
                end else if (tmo_cnt_d == TMO_DONE) begin
                    tmo_cnt_d  = '0;
                    filt_cnt_d = '0;
                    if (retry_q < RTY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = RST_HOLD;
                    end else begin
                        state_d = FAIL;
                    end
                end
            end

            LOCKED: begin
                if (accept) begin
                    idsel_d  = cfg.cfg_idsel;
                    fbdsel_d = cfg.cfg_fbdsel;
                    odsel_d  = cfg.cfg_odsel;
                    retry_d  = '0;
                    state_d  = RST_HOLD;
                end else if (!lock_s) begin
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                    retry_d = '0;
                    state_d = RST_HOLD;
                end
            end

            FAIL: begin
                if (accept) begin
                    idsel_d  = cfg.cfg_idsel;
                    fbdsel_d = cfg.cfg_fbdsel;
                    odsel_d  = cfg.cfg_odsel;
                    retry_d  = '0;
                    state_d  = RST_HOLD;
                end
            end

            default: state_d = RST_HOLD;
        endcase
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q    <= RST_HOLD;
            rst_cnt_q  <= '0;
            filt_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            retry_q    <= '0;
            loss_q     <= '0;
            idsel_q    <= IDSEL_INIT;
            fbdsel_q   <= FBDSEL_INIT;
            odsel_q    <= ODSEL_INIT;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            filt_cnt_q <= filt_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            retry_q    <= retry_d;
            loss_q     <= loss_d;
            idsel_q    <= idsel_d;
            fbdsel_q   <= fbdsel_d;
            odsel_q    <= odsel_d;
        end
    end

    // Status outputs decode the state register only, so they are glitch-free.
    assign cfg.cfg_ready   = cfg_ready_w;
    assign pll_reset       = (state_q == RST_HOLD) || (state_q == FAIL);
    assign busy            = (state_q == RST_HOLD) || (state_q == WAIT_LOCK);
    assign locked          = (state_q == LOCKED);
    assign err             = (state_q == FAIL);
    assign lock_loss_cnt   = loss_q;
    assign pll_idsel       = idsel_q;
    assign pll_fbdsel      = fbdsel_q;
    assign pll_odsel       = odsel_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl: power-up, glitch, reconfig, timeout/FAIL,
// lock loss with saturation, and asynchronous reset.
module tb_pll_reconfig_ctrl;

    localparam int         W            = 6;
    localparam int         RST_CYCLES   = 4;
    localparam int         LOCK_FILTER  = 8;
    localparam int         LOCK_TIMEOUT = 32;
    localparam int         MAX_RETRY    = 2;
    localparam logic [5:0] ID_INIT      = 6'd1;
    localparam logic [5:0] FB_INIT      = 6'd2;
    localparam logic [5:0] OD_INIT      = 6'd3;

    logic         clkin    = 1'b0;
    logic         reset    = 1'b1;
    logic         pll_lock = 1'b0;
    logic         pll_reset;
    logic [W-1:0] pll_idsel;
    logic [W-1:0] pll_fbdsel;
    logic [W-1:0] pll_odsel;
    logic         locked;
    logic         busy;
    logic         err;
    logic [7:0]   lock_loss_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_id   = 1;
    int exp_fb   = 2;
    int exp_od   = 3;
    int exp_loss = 0;

    pll_reconfig_ctrl_if #(.IDIV_W(W), .FBDIV_W(W), .ODIV_W(W)) cfg_if ();

    pll_reconfig_ctrl #(
        .IDIV_W       (W),
        .FBDIV_W      (W),
        .ODIV_W       (W),
        .IDSEL_INIT   (ID_INIT),
        .FBDSEL_INIT  (FB_INIT),
        .ODSEL_INIT   (OD_INIT),
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_FILTER  (LOCK_FILTER),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clkin         (clkin),
        .reset         (reset),
        .cfg           (cfg_if),
        .pll_lock      (pll_lock),
        .pll_reset     (pll_reset),
        .pll_idsel     (pll_idsel),
        .pll_fbdsel    (pll_fbdsel),
        .pll_odsel     (pll_odsel),
        .locked        (locked),
        .busy          (busy),
        .err           (err),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clkin = ~clkin;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic offer(input int id, input int fb, input int od);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_idsel  = W'(id);
        cfg_if.cfg_fbdsel = W'(fb);
        cfg_if.cfg_odsel  = W'(od);
    endtask

    task automatic withdraw();
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_idsel  = 6'h3F;
        cfg_if.cfg_fbdsel = 6'h3F;
        cfg_if.cfg_odsel  = 6'h3F;
    endtask

    task automatic check_sels(input string tag);
        check({tag, "_idsel"},  32'(pll_idsel),  exp_id);
        check({tag, "_fbdsel"}, 32'(pll_fbdsel), exp_fb);
        check({tag, "_odsel"},  32'(pll_odsel),  exp_od);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pll_reset"}, 32'(pll_reset), 1);
        check({tag, "_locked"},    32'(locked), 0);
        check({tag, "_cfg_ready"}, 32'(cfg_if.cfg_ready), 0);
        check({tag, "_busy"},      32'(busy), 1);
        check({tag, "_err"},       32'(err), 0);
        check({tag, "_loss_cnt"},  32'(lock_loss_cnt), 0);
        check({tag, "_idsel"},     32'(pll_idsel), 32'(ID_INIT));
        check({tag, "_fbdsel"},    32'(pll_fbdsel), 32'(FB_INIT));
        check({tag, "_odsel"},     32'(pll_odsel), 32'(OD_INIT));
    endtask

    // Entry: 1 time unit after the edge on which RST_HOLD began (counter at zero).
    // PLL lock rises 'gap' cycles after pll_reset falls; optional 1-cycle dropout after 5.
    task automatic do_lock(input string tag, input int gap, input bit glitch);
        pll_lock = 1'b0;
        tick(RST_CYCLES - 1);
        check({tag, "_rst_hi"}, 32'(pll_reset), 1);
        check({tag, "_busy_rst"}, 32'(busy), 1);
        tick(1);
        check({tag, "_rst_lo"}, 32'(pll_reset), 0);
        check({tag, "_busy_wait"}, 32'(busy), 1);
        tick(gap);
        pll_lock = 1'b1;
        if (glitch) begin
            tick(5);
            pll_lock = 1'b0;
            tick(1);
            pll_lock = 1'b1;
        end
        tick(LOCK_FILTER + 1);
        check({tag, "_not_yet"}, 32'(locked), 0);
        tick(1);
        check({tag, "_locked"}, 32'(locked), 1);
        check({tag, "_ready"}, 32'(cfg_if.cfg_ready), 1);
        check({tag, "_busy_lk"}, 32'(busy), 0);
        check({tag, "_rst_lk"}, 32'(pll_reset), 0);
        check_sels(tag);
    endtask

    // Entry: in LOCKED. One-cycle dropout of pll_lock; RST_HOLD entered on the third edge.
    task automatic lose_lock(input string tag);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(1);
        check({tag, "_still_locked"}, 32'(locked), 1);
        tick(1);
        if (exp_loss < 255) exp_loss++;
        check({tag, "_locked_fall"}, 32'(locked), 0);
        check({tag, "_rst"}, 32'(pll_reset), 1);
        check({tag, "_cnt"}, 32'(lock_loss_cnt), exp_loss);
        check_sels(tag);
    endtask

    initial begin
        withdraw();

        // Reset state, then power-up lock.
        tick(2);
        check_reset_state("por");
        reset = 1'b0;
        do_lock("pwr", 10, 1'b0);

        // Reconfig 3/12/8, relock with a glitch during WAIT_LOCK.
        offer(3, 12, 8);
        check("rc_ready", 32'(cfg_if.cfg_ready), 1);
        tick(1);
        withdraw();
        exp_id = 3; exp_fb = 12; exp_od = 8;
        check("rc_rst", 32'(pll_reset), 1);
        check("rc_locked", 32'(locked), 0);
        check("rc_ready_lo", 32'(cfg_if.cfg_ready), 0);
        check_sels("rc");
        do_lock("glitch", 3, 1'b1);

        // Reconfig again; lock completes on the very cycle the timeout expires.
        offer(21, 42, 7);
        tick(1);
        withdraw();
        exp_id = 21; exp_fb = 42; exp_od = 7;
        check_sels("rc2");
        do_lock("bound", LOCK_TIMEOUT - LOCK_FILTER - 2, 1'b0);

        // Timeout: lock never comes; three attempts then FAIL.
        pll_lock = 1'b0;
        offer(10, 20, 30);
        tick(1);
        withdraw();
        exp_id = 10; exp_fb = 20; exp_od = 30;
        check("to_rst0", 32'(pll_reset), 1);
        for (int a = 0; a <= MAX_RETRY; a++) begin
            tick(RST_CYCLES - 1);
            check("to_rst_hi", 32'(pll_reset), 1);
            tick(1);
            check("to_rst_lo", 32'(pll_reset), 0);
            offer(9, 9, 9);
            tick(LOCK_TIMEOUT - 1);
            check("to_wait", 32'(pll_reset), 0);
            check("to_busy", 32'(busy), 1);
            check("to_ignored_rdy", 32'(cfg_if.cfg_ready), 0);
            withdraw();
            tick(1);
            check("to_end_rst", 32'(pll_reset), 1);
            check("to_err", 32'(err), (a == MAX_RETRY) ? 1 : 0);
            check("to_end_rdy", 32'(cfg_if.cfg_ready), (a == MAX_RETRY) ? 1 : 0);
            check_sels("to");
        end
        tick(3);
        check("fail_err_sticky", 32'(err), 1);
        check("fail_rst", 32'(pll_reset), 1);
        check("fail_busy", 32'(busy), 0);
        check("fail_locked", 32'(locked), 0);

        // New cfg from FAIL clears err; retry counter must restart from zero.
        offer(4, 5, 6);
        tick(1);
        withdraw();
        exp_id = 4; exp_fb = 5; exp_od = 6;
        check("frec_err", 32'(err), 0);
        check("frec_rst", 32'(pll_reset), 1);
        check("frec_rdy", 32'(cfg_if.cfg_ready), 0);
        check_sels("frec");
        tick(RST_CYCLES);
        check("frec_wait", 32'(pll_reset), 0);
        tick(LOCK_TIMEOUT);
        check("frec_retry_rst", 32'(pll_reset), 1);
        check("frec_retry_err", 32'(err), 0);
        do_lock("frec_lock", 10, 1'b0);

        // First lock loss, then accept and loss on the same cycle.
        lose_lock("loss1");
        do_lock("loss1_relock", 10, 1'b0);
        pll_lock = 1'b0;
        tick(2);
        offer(7, 7, 7);
        check("acc_loss_rdy", 32'(cfg_if.cfg_ready), 1);
        tick(1);
        withdraw();
        exp_id = 7; exp_fb = 7; exp_od = 7;
        check("acc_loss_rst", 32'(pll_reset), 1);
        check("acc_loss_cnt", 32'(lock_loss_cnt), exp_loss);
        check_sels("acc_loss");
        do_lock("acc_loss_relock", 10, 1'b0);

        // Drive the loss counter into saturation.
        for (int i = 0; i < 259; i++) begin
            lose_lock("sat");
            do_lock("sat_relock", 10, 1'b0);
        end
        check("loss_sat", 32'(lock_loss_cnt), 255);

        // Asynchronous reset in the middle of WAIT_LOCK.
        pll_lock = 1'b0;
        tick(3);
        tick(RST_CYCLES);
        check("ar_wait", 32'(pll_reset), 0);
        tick(2);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("ar");
        tick(2);
        reset = 1'b0;
        exp_id = 1; exp_fb = 2; exp_od = 3; exp_loss = 0;
        do_lock("ar_relock", 10, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
